// File: rtl/ram_loader_pkg.sv
// ram_loader shared types: loader FSM state encoding and the
// bytes-per-word helper used to size the byte packer.
package ram_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_loader_byte_packer.sv
// Packs accepted bytes little-endian into a WIDTH-bit word.
// Ports: i_clear restarts at byte 0, i_accept/i_data take one byte,
// o_word_valid/o_word present the completed word in the accept cycle.
module ram_loader_byte_packer
  import ram_loader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [7:0]       i_data,
  output logic             o_word_valid,
  output logic [WIDTH-1:0] o_word
);

  localparam int BYTES = bytes_per_word(WIDTH);
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(BYTES - 1);

  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_pack;
  logic [WIDTH-1:0] w_word;

  // Current byte merged into the held partial word, so the full
  // word is available in the same cycle its last byte arrives.
  always_comb begin
    w_word = r_pack;
    for (int k = 0; k < BYTES; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_word[8*k +: 8] = i_data;
      end
    end
  end

  assign o_word_valid = i_accept && (r_idx == LAST);
  assign o_word       = w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_pack <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_pack <= '0;
    end else if (i_accept) begin
      r_pack <= w_word;
      r_idx  <= o_word_valid ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Streams bytes into a RAM write port as little-endian WIDTH-bit words
// at consecutive (wrapping) addresses. Ports: start/base_addr/length
// command, s_data/s_valid/s_ready byte stream, busy/done status,
// registered wr_en/wr_addr/wr_data RAM write port.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   length,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             busy,
  output logic             done,
  output logic             wr_en,
  output logic [ADDRW-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  localparam logic [ADDRW:0]   DEPTH_W  = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW-1:0] ADDR_MAX = ADDRW'(DEPTH - 1);

  state_t           r_state;
  logic [ADDRW-1:0] r_addr;
  logic [ADDRW:0]   r_left;
  logic             r_wr_en;
  logic [ADDRW-1:0] r_wr_addr;
  logic [WIDTH-1:0] r_wr_data;

  logic [ADDRW:0]   w_len_sat;
  logic             w_accept;
  logic             w_clear;
  logic             w_word_valid;
  logic [WIDTH-1:0] w_word;

  assign w_len_sat = (length > DEPTH_W) ? DEPTH_W : length;

  // Handshake and status decode from registered state only.
  assign s_ready  = (r_state == S_LOAD) && (r_left != '0);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign w_accept = s_valid && s_ready;
  assign w_clear  = (r_state == S_IDLE) && start;

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

  ram_loader_byte_packer #(
    .WIDTH(WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_accept    (w_accept),
    .i_data      (s_data),
    .o_word_valid(w_word_valid),
    .o_word      (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_left  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= base_addr;
            r_left  <= w_len_sat;
            r_state <= (w_len_sat == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_word_valid) begin
            r_addr <= (r_addr == ADDR_MAX) ? '0 : r_addr + 1'b1;
            r_left <= r_left - 1'b1;
            if (r_left == (ADDRW+1)'(1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write port registers hold their contents between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_word_valid;
      if (w_word_valid) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: a WIDTH=8 and a WIDTH=16 instance,
// both DEPTH=256, driven and sampled on the falling clock edge.
module tb_ram_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st8, sv8, rdy8, busy8, done8, we8;
  logic [7:0]  ba8, sd8, wa8, wd8;
  logic [8:0]  len8;

  logic        st16, sv16, rdy16, busy16, done16, we16;
  logic [7:0]  ba16, sd16, wa16;
  logic [8:0]  len16;
  logic [15:0] wd16;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  la8[$];
  logic [7:0]  ld8[$];
  logic [7:0]  la16[$];
  logic [15:0] ld16[$];
  int   consec16 = 0;
  logic prev16 = 1'b0;

  ram_loader #(.WIDTH(8), .DEPTH(256)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .base_addr(ba8),
    .length(len8), .s_data(sd8), .s_valid(sv8), .s_ready(rdy8),
    .busy(busy8), .done(done8), .wr_en(we8), .wr_addr(wa8),
    .wr_data(wd8)
  );

  ram_loader #(.WIDTH(16), .DEPTH(256)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(st16), .base_addr(ba16),
    .length(len16), .s_data(sd16), .s_valid(sv16), .s_ready(rdy16),
    .busy(busy16), .done(done16), .wr_en(we16), .wr_addr(wa16),
    .wr_data(wd16)
  );

  always @(negedge clk) begin
    if (we8) begin
      la8.push_back(wa8);
      ld8.push_back(wd8);
    end
    if (we16) begin
      la16.push_back(wa16);
      ld16.push_back(wd16);
    end
    if (we16 && prev16) consec16 <= consec16 + 1;
    prev16 <= we16;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    int base_n;
    logic ok;
    st8 = 0; sv8 = 0; ba8 = 0; len8 = 0; sd8 = 0;
    st16 = 0; sv16 = 0; ba16 = 0; len16 = 0; sd16 = 0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy8, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_we", we8, 1'b0);
    chk("rst_wa", wa8, 8'h00);
    chk("rst_wd16", wd16, 16'h0000);
    rst_n = 1;
    @(negedge clk);

    // single-byte words, cycle exact
    ba8 = 8'h10; len8 = 9'd3; st8 = 1;
    @(negedge clk);
    st8 = 0;
    chk("t1_busy", busy8, 1'b1);
    chk("t1_rdy", rdy8, 1'b1);
    chk("t1_we0", we8, 1'b0);
    sd8 = 8'hA1; sv8 = 1;
    @(negedge clk);
    chk("t1_we_a", we8, 1'b1);
    chk("t1_wa_a", wa8, 8'h10);
    chk("t1_wd_a", wd8, 8'hA1);
    sd8 = 8'hB2;
    @(negedge clk);
    chk("t1_wa_b", wa8, 8'h11);
    chk("t1_wd_b", wd8, 8'hB2);
    chk("t1_done_b", done8, 1'b0);
    sd8 = 8'hC3;
    @(negedge clk);
    chk("t1_we_c", we8, 1'b1);
    chk("t1_wa_c", wa8, 8'h12);
    chk("t1_wd_c", wd8, 8'hC3);
    chk("t1_done_c", done8, 1'b1);
    chk("t1_busy_c", busy8, 1'b1);
    chk("t1_rdy_c", rdy8, 1'b0);
    sv8 = 0;
    @(negedge clk);
    chk("t1_busy_end", busy8, 1'b0);
    chk("t1_done_end", done8, 1'b0);
    chk("t1_we_end", we8, 1'b0);
    chk("t1_wa_hold", wa8, 8'h12);

    // 16-bit packing
    la16.delete(); ld16.delete();
    ba16 = 8'h00; len16 = 9'd2; st16 = 1;
    @(negedge clk);
    st16 = 0;
    sv16 = 1;
    sd16 = 8'h34; @(negedge clk);
    sd16 = 8'h12; @(negedge clk);
    sd16 = 8'h78; @(negedge clk);
    sd16 = 8'h56; @(negedge clk);
    chk("t2_done", done16, 1'b1);
    chk("t2_we", we16, 1'b1);
    sv16 = 0;
    repeat (3) @(negedge clk);
    chk("t2_n", la16.size(), 2);
    chk("t2_a0", la16[0], 8'h00);
    chk("t2_d0", ld16[0], 16'h1234);
    chk("t2_a1", la16[1], 8'h01);
    chk("t2_d1", ld16[1], 16'h5678);
    chk("t2_consec", consec16, 0);

    // address wrap
    la8.delete(); ld8.delete();
    ba8 = 8'hFE; len8 = 9'd4; st8 = 1;
    @(negedge clk);
    st8 = 0;
    sv8 = 1;
    for (int i = 1; i <= 4; i++) begin
      sd8 = 8'(i);
      @(negedge clk);
    end
    sv8 = 0;
    repeat (3) @(negedge clk);
    chk("t3_n", la8.size(), 4);
    chk("t3_a0", la8[0], 8'hFE);
    chk("t3_a1", la8[1], 8'hFF);
    chk("t3_a2", la8[2], 8'h00);
    chk("t3_a3", la8[3], 8'h01);
    chk("t3_d3", ld8[3], 8'h04);

    // stall 1-0-0-1
    la16.delete(); ld16.delete();
    ba16 = 8'h05; len16 = 9'd1; st16 = 1;
    @(negedge clk);
    st16 = 0;
    sd16 = 8'hCD; sv16 = 1;
    @(negedge clk);
    chk("t4_we_b0", we16, 1'b0);
    sd16 = 8'hEE; sv16 = 0;
    @(negedge clk);
    chk("t4_we_s1", we16, 1'b0);
    chk("t4_rdy_s1", rdy16, 1'b1);
    @(negedge clk);
    chk("t4_we_s2", we16, 1'b0);
    sd16 = 8'hAB; sv16 = 1;
    @(negedge clk);
    chk("t4_we", we16, 1'b1);
    chk("t4_wa", wa16, 8'h05);
    chk("t4_wd", wd16, 16'hABCD);
    chk("t4_done", done16, 1'b1);
    sv16 = 0;
    repeat (3) @(negedge clk);
    chk("t4_n", la16.size(), 1);

    // zero length
    base_n = la8.size();
    ba8 = 8'h33; len8 = 9'd0; st8 = 1;
    @(negedge clk);
    st8 = 0;
    chk("t5_done", done8, 1'b1);
    chk("t5_busy", busy8, 1'b1);
    chk("t5_we", we8, 1'b0);
    chk("t5_rdy", rdy8, 1'b0);
    @(negedge clk);
    chk("t5_done_end", done8, 1'b0);
    chk("t5_busy_end", busy8, 1'b0);
    repeat (2) @(negedge clk);
    chk("t5_nowr", la8.size(), base_n);

    // saturation with an ignored mid-load start
    la8.delete(); ld8.delete();
    ba8 = 8'h20; len8 = 9'd300; st8 = 1;
    @(negedge clk);
    st8 = 0;
    cnt = 0;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done8) begin
        ok = 1'b1;
        break;
      end
      sd8 = 8'(cnt);
      sv8 = 1;
      st8 = (c == 10);
      ba8 = 8'h00;
      len8 = 9'd5;
      if (rdy8) cnt++;
      @(negedge clk);
    end
    sv8 = 0; st8 = 0;
    chk("t6_done_seen", ok, 1'b1);
    chk("t6_accepted", cnt, 256);
    repeat (3) @(negedge clk);
    chk("t6_n", la8.size(), 256);
    chk("t6_a0", la8[0], 8'h20);
    chk("t6_d0", ld8[0], 8'h00);
    chk("t6_a224", la8[224], 8'h00);
    chk("t6_d224", ld8[224], 8'hE0);
    chk("t6_a255", la8[255], 8'h1F);
    chk("t6_d255", ld8[255], 8'hFF);

    // reset mid-load
    la16.delete(); ld16.delete();
    ba16 = 8'h40; len16 = 9'd1; st16 = 1;
    @(negedge clk);
    st16 = 0;
    sd16 = 8'h99; sv16 = 1;
    @(negedge clk);
    sv16 = 0;
    chk("t7_busy_pre", busy16, 1'b1);
    chk("t7_rdy_pre", rdy16, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("t7_busy", busy16, 1'b0);
    chk("t7_rdy", rdy16, 1'b0);
    chk("t7_done", done16, 1'b0);
    chk("t7_we", we16, 1'b0);
    chk("t7_wa", wa16, 8'h00);
    chk("t7_wd", wd16, 16'h0000);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    ba16 = 8'h41; len16 = 9'd1; st16 = 1;
    @(negedge clk);
    st16 = 0;
    sd16 = 8'h22; sv16 = 1;
    @(negedge clk);
    chk("t7_we_b0", we16, 1'b0);
    sd16 = 8'h11;
    @(negedge clk);
    chk("t7_we_new", we16, 1'b1);
    chk("t7_wa_new", wa16, 8'h41);
    chk("t7_wd_new", wd16, 16'h1122);
    chk("t7_done_new", done16, 1'b1);
    sv16 = 0;
    repeat (3) @(negedge clk);
    chk("t7_n", la16.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
